// File: rtl/vga_pkg.sv
// Shared VGA timing constants and framebuffer geometry defaults for the
// scan-out and arbitration blocks.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;

  localparam int FB_DEPTH_DEF = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W_DEF   = 19;
  localparam int DATA_W_DEF   = 1;
endpackage

// File: rtl/vga_fb_arb_stats.sv
// Saturating 16-bit event counter used for write-stall statistics.
module vga_fb_arb_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads have strict priority over
// draw-engine writes. Define VGA_FB_ARB_STATS_EN to add the wr_stall_cnt port.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int FB_DEPTH = FB_DEPTH_DEF
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              wr_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VGA_FB_ARB_STATS_EN
  ,
  output logic [15:0]       wr_stall_cnt
`endif
);
  // Handshake: a write transfers in any cycle where wr_req && wr_ready;
  // wr_ready is simply the absence of a display request that cycle.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(FB_DEPTH);

  logic       disp_ok;
  logic       wr_ok;
  logic [2:0] trk_v;
  logic [1:0] trk_oor;

  assign wr_ready = !disp_req;
  assign disp_ok  = {1'b0, disp_addr} < DEPTH_L;
  assign wr_ok    = {1'b0, wr_addr} < DEPTH_L;

  // trk_v[0] aligns with the RAM command, trk_v[1] with mem_rdata,
  // trk_v[2] with the registered disp_data.
  assign disp_valid = trk_v[2];

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_err    <= 1'b0;
      trk_v     <= '0;
      trk_oor   <= '0;
      disp_data <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if (disp_req) begin
        if (disp_ok) begin
          mem_en   <= 1'b1;
          mem_addr <= disp_addr;
        end
      end else if (wr_req) begin
        if (wr_ok) begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= wr_addr;
          mem_wdata <= wr_data;
        end else begin
          wr_err <= 1'b1;
        end
      end
      trk_v     <= {trk_v[1:0], disp_req};
      trk_oor   <= {trk_oor[0], !disp_ok};
      disp_data <= (trk_v[1] && !trk_oor[1]) ? mem_rdata : '0;
    end
  end

`ifdef VGA_FB_ARB_STATS_EN
  vga_fb_arb_stats u_stats (
    .clk   (clk_50),
    .rst_n (reset_n),
    .inc   (wr_req && !wr_ready),
    .cnt   (wr_stall_cnt)
  );
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized scoreboard bench for vga_fb_arbiter against a pixel-array model
// and a behavioural single-port RAM.
module tb_vga_fb_arbiter;
  localparam int AW    = 19;
  localparam int DEPTH = 307200;

  logic          clk_50 = 1'b0;
  logic          reset_n = 1'b1;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_data;
  logic          disp_valid;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic          wr_data = 1'b0;
  logic          wr_ready;
  logic          wr_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic          mem_wdata;
  logic          mem_rdata = 1'b0;
`ifdef VGA_FB_ARB_STATS_EN
  logic [15:0]   wr_stall_cnt;
`endif

  vga_fb_arbiter dut (
    .clk_50     (clk_50),
    .reset_n    (reset_n),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .wr_err     (wr_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef VGA_FB_ARB_STATS_EN
    ,
    .wr_stall_cnt (wr_stall_cnt)
`endif
  );

  // clock / reset block
  always #10 clk_50 = ~clk_50;

  int unsigned cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  // behavioural RAM, one-cycle read latency
  bit ram [0:DEPTH-1];
  always @(posedge clk_50) begin
    if (mem_en && (int'(mem_addr) < DEPTH)) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // reference model and scoreboard state
  bit            fb [0:DEPTH-1];
  logic [32:0]   exp_rd_q[$];
  logic [19:0]   exp_wr_q[$];
  bit            err_model = 0;
  int unsigned   err_cyc = 0;
  int unsigned   stall_model = 0;
  bit            wr_pend = 0;
  logic [AW-1:0] wa = '0;
  logic          wd = 1'b0;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic load_wr(input logic [AW-1:0] a, input logic d);
    wr_pend = 1;
    wa = a;
    wd = d;
  endtask

  task automatic cycle(input logic rd, input logic [AW-1:0] ra);
    logic d;
    disp_req  = rd;
    disp_addr = ra;
    wr_req    = wr_pend;
    wr_addr   = wa;
    wr_data   = wd;
    if (rd) begin
      d = (int'(ra) < DEPTH) ? fb[ra] : 1'b0;
      exp_rd_q.push_back({cyc + 32'd3, d});
      if (wr_pend) stall_model++;
    end else if (wr_pend) begin
      if (int'(wa) < DEPTH) begin
        fb[wa] = wd;
        exp_wr_q.push_back({wa, wd});
      end else if (!err_model) begin
        err_model = 1;
        err_cyc   = cyc;
      end
      wr_pend = 0;
    end
    @(posedge clk_50);
    #1;
    disp_req = 1'b0;
    wr_req   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0);
  endtask

  task automatic do_reset();
    disp_req = 1'b0;
    wr_req   = 1'b0;
    reset_n  = 1'b0;
    #($urandom_range(5, 30));
    chk("rst_disp_valid", 32'(disp_valid), 0);
    chk("rst_disp_data",  32'(disp_data), 0);
    chk("rst_mem_en",     32'(mem_en), 0);
    chk("rst_mem_we",     32'(mem_we), 0);
    chk("rst_mem_addr",   32'(mem_addr), 0);
    chk("rst_mem_wdata",  32'(mem_wdata), 0);
    chk("rst_wr_err",     32'(wr_err), 0);
    exp_rd_q.delete();
    exp_wr_q.delete();
    err_model   = 0;
    stall_model = 0;
    wr_pend     = 0;
    @(negedge clk_50);
    #1 reset_n = 1'b1;
    #1;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 19) == 0) return AW'(DEPTH + $urandom_range(0, 100));
    return AW'($urandom_range(0, 63));
  endfunction

  // monitor: pops expectations whenever the DUT presents a response
  always @(negedge clk_50) begin
    if (reset_n) begin
      logic [32:0] e;
      logic [19:0] w;
      chk("wr_ready", 32'(wr_ready), 32'(!disp_req));
      chk("wr_err", 32'(wr_err), 32'(err_model && (cyc > err_cyc)));
      if (disp_valid) begin
        if (exp_rd_q.size() == 0) begin
          chk("unexpected_disp_valid", 1, 0);
        end else begin
          e = exp_rd_q.pop_front();
          chk("disp_latency", cyc, e[32:1]);
          chk("disp_data", 32'(disp_data), 32'(e[0]));
        end
      end
      if (mem_en && (int'(mem_addr) >= DEPTH)) chk("mem_addr_range", 32'(mem_addr), DEPTH - 1);
      if (mem_en && mem_we) begin
        if (exp_wr_q.size() == 0) begin
          chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          w = exp_wr_q.pop_front();
          chk("write_addr", 32'(mem_addr), 32'(w[19:1]));
          chk("write_data", 32'(mem_wdata), 32'(w[0]));
        end
      end
    end
  end

  initial begin
    int gap;
    logic rd;
    #2;
    do_reset();

    // first request straight after release
    cycle(1'b1, 19'd5);
    idle(4);

    // write then read-after-write, then an out-of-range read with stale rdata=1
    load_wr(19'd100, 1'b1);
    cycle(1'b0, '0);
    cycle(1'b1, 19'd100);
    cycle(1'b0, '0);
    cycle(1'b1, AW'(DEPTH));
    idle(5);

    // display every second cycle while the writer keeps a request pending
    for (int i = 0; i < 24; i++) begin
      if (!wr_pend) load_wr(AW'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      cycle(i % 2 == 0, AW'($urandom_range(0, 63)));
    end
    idle(5);

    // out-of-range write: never reaches RAM, sticky error
    load_wr(AW'(DEPTH), 1'b1);
    cycle(1'b0, '0);
    idle(2);
    @(negedge clk_50); #1;
    chk("wr_err_set", 32'(wr_err), 1);
    idle(10);
    @(negedge clk_50); #1;
    chk("wr_err_sticky", 32'(wr_err), 1);

    // randomized traffic, mostly protocol-compliant with rare back-to-back reads
    gap = 2;
    for (int i = 0; i < 3000; i++) begin
      if (!wr_pend && ($urandom_range(0, 9) < 6)) load_wr(pick_addr(), 1'($urandom_range(0, 1)));
      rd = ((gap >= 2) && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 49) == 0);
      gap = rd ? 1 : gap + 1;
      cycle(rd, pick_addr());
    end
    idle(6);
    @(negedge clk_50); #1;
    chk("drain_rd_q", exp_rd_q.size(), 0);
    chk("drain_wr_q", exp_wr_q.size(), 0);
`ifdef VGA_FB_ARB_STATS_EN
    chk("stall_cnt", 32'(wr_stall_cnt), (stall_model > 65535) ? 32'hFFFF : stall_model);
`endif

    // reset one cycle after a read: it must never be answered
    cycle(1'b1, 19'd5);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, '0);
      @(negedge clk_50); #1;
      chk("no_valid_after_reset", 32'(disp_valid), 0);
    end

`ifdef VGA_FB_ARB_STATS_EN
    load_wr(19'd7, 1'b1);
    for (int i = 0; i < 70000; i++) cycle(1'b1, AW'(DEPTH));
    cycle(1'b0, '0);
    idle(5);
    @(negedge clk_50); #1;
    chk("stall_cnt_sat", 32'(wr_stall_cnt), 32'hFFFF);
`endif

    idle(6);
    @(negedge clk_50); #1;
    chk("final_rd_q", exp_rd_q.size(), 0);
    chk("final_wr_q", exp_wr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
